rr_read_arbiter: RTL and testbench
==================================

# rr_read_arbiter

Parametrised round-robin read arbiter that lets `NUM_CHANNELS` strip drivers share one synchronous BRAM read port. It generalises the fixed 8-channel `bus_arbiter` in three ways: flattened vector ports, configurable BRAM read latency, and pipelined issue of up to one read per clock. Each channel may have at most one read outstanding. The block sits between the strip drivers' `mem_req`/`mem_addr`/`mem_rdy`/`mem_data` ports and the `bram` read side, in the `clk_50mhz` domain.

## Interface
- `NUM_CHANNELS`, 8: number of requesters, 2..16; need not be a power of two.
- `ADDRESS_WIDTH`, 13: width of the BRAM read address.
- `DATA_WIDTH`, 8: width of the BRAM read data.
- `READ_LATENCY`, 1: BRAM cycles from sampling `mem_raddr` to `mem_rdata` being valid, 1..3.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_req`  in  NUM_CHANNELS  per-channel read request, level-sensitive.
- `data_addr`  in  NUM_CHANNELS*ADDRESS_WIDTH  per-channel address; channel i is `[i*AW +: AW]`.
- `data_rdy`  out  NUM_CHANNELS  one-cycle pulse per channel when its read data is valid.
- `data_out`  out  NUM_CHANNELS*DATA_WIDTH  per-channel data register; channel i is `[i*DW +: DW]`.
- `mem_raddr`  out  ADDRESS_WIDTH  registered BRAM read address.
- `mem_ren`  out  1  registered BRAM read enable.
- `mem_rdata`  in  DATA_WIDTH  BRAM read data.

## Operation
- **Eligibility.** Channel i is eligible when `data_req[i] & ~inflight[i] & ~data_rdy[i]`.
- **Grant.** Combinational, each cycle. Search eligible channels starting at `ptr+1` and wrap modulo `NUM_CHANNELS`; the first hit wins. At most one grant per cycle.
- **On grant of channel g:**
  - `mem_raddr <= data_addr[g]`, `mem_ren <= 1`.
  - `ptr <= g`, `inflight[g] <= 1`.
  - Push `{valid=1, tag=g}` into a tag shift register of depth `READ_LATENCY+1`.
- **No grant:** `mem_ren <= 0`, `mem_raddr` holds its value, and `{valid=0}` is pushed.
- **Completion.** When the tail tag is valid with tag t:
  - `data_out[t] <= mem_rdata` and `data_rdy[t] <= 1` for one cycle.
  - `inflight[t] <= 0` on the same edge.
- **Data hold.** `data_out[i]` holds its value until channel i's next completion. Other channels' data is never disturbed.
- **Requester contract.**
  - Hold `data_addr[i]` stable from raising `data_req[i]` until `data_rdy[i]` is seen.
  - The requester may then present a new address, with `data_req` still high, from the cycle after the `data_rdy` pulse.
  - Dropping `data_req[i]` while in flight does not cancel the read: `data_rdy` still pulses.
- **Fairness.** Every requesting channel is granted within `NUM_CHANNELS` cycles of becoming eligible.
- **Tag width.** `$clog2(NUM_CHANNELS)`. `ptr` wrap uses an explicit compare to `NUM_CHANNELS-1`, not natural overflow.

## Timing
- **Reset values:**
  - Outputs: `data_rdy=0`, `data_out=0`, `mem_raddr=0`, `mem_ren=0`.
  - Internal: `inflight=0`, all tags invalid, `ptr=NUM_CHANNELS-1`, so channel 0 has first priority.
- **Latency.** If channel i is granted in cycle T, `data_rdy[i]` is high in cycle `T+READ_LATENCY+2`. With the default this is T+3.
- **Re-eligibility.** The earliest cycle a channel can be granted again is the cycle after its `data_rdy`. Per-channel throughput is therefore one read per `READ_LATENCY+3` cycles.
- **Aggregate throughput.** One read per cycle when at least `READ_LATENCY+3` channels request continuously.
- **Simultaneous events.**
  - A completion and a grant for different channels in the same cycle are both processed.
  - A completion never coincides with a grant of the same channel, because eligibility masks it.
- **Reset mid-operation.** `rst` flushes all tags and clears `inflight`. No `data_rdy` is emitted for reads that were in flight. `data_out` returns to 0.
- **Idle bus.** `mem_ren=0` whenever there is no grant. The BRAM read side may ignore `mem_raddr` in that case.

## Test plan
- **Single channel.** Reset, then `data_req[0]=1` with addr 0x010 and the BRAM model returning 0xA5 (`READ_LATENCY=1`). Required: `mem_raddr=0x010` with `mem_ren=1` one cycle after grant; `data_rdy[0]` pulses 3 cycles after grant; `data_out[0]=0xA5`, held afterwards.
- **All channels at once.** All 8 raise `data_req` in the same cycle with addr `=i*900`. Required: grants in order 0,1,…,7 on consecutive cycles; `data_rdy[i]` in cycle `grant_i+3`; each `data_out[i]` equals `mem[i*900]`.
- **Back-to-back on one channel.** Channel 3 keeps `data_req` high and advances its address on each `data_rdy`; channel 5 requests continuously. Required: channel 3 is granted every 4th cycle; channel 5 interleaves with it; no grant is issued to a channel whose `inflight` bit is set.
- **Reset mid-flight.** With `READ_LATENCY=3`, pulse `rst` one cycle after granting channels 0 and 1. Required: no `data_rdy` for either read; all outputs are 0; the first grant after reset goes to channel 0.
- **Non-power-of-two wrap.** `NUM_CHANNELS=3`; channels 0 and 2 request continuously while `ptr=2`. Required: the next grant is channel 0, not an out-of-range index; grants then alternate 0,2,0,2 for as long as each channel is eligible.
- **Dropped request.** Drop `data_req[4]` one cycle after its grant. Required: `data_rdy[4]` still pulses at grant+3 with the correct data, and channel 4 is not granted again afterwards.

Source files
------------

// File: rtl/rr_read_arbiter.sv
// Round-robin arbiter sharing one synchronous BRAM read port among NUM_CHANNELS requesters.
// Latency: grant in cycle T -> mem_raddr/mem_ren in T+1 -> data_rdy pulse in T+READ_LATENCY+2.
// Backpressure: none toward the BRAM; a channel is simply not granted while its read is in flight or its data_rdy is pulsing.
module rr_read_arbiter #(
  parameter int NUM_CHANNELS  = 8,
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 8,
  parameter int READ_LATENCY  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CHANNELS-1:0]               data_req,
  input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] data_addr,
  output logic [NUM_CHANNELS-1:0]               data_rdy,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]    data_out,
  output logic [ADDRESS_WIDTH-1:0]              mem_raddr,
  output logic                                  mem_ren,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata
);

  localparam int TAG_W = $clog2(NUM_CHANNELS);
  // One stage for the registered address, READ_LATENCY stages for the BRAM itself.
  localparam int DEPTH = READ_LATENCY + 1;
  localparam logic [TAG_W-1:0] LAST_CH = TAG_W'(NUM_CHANNELS - 1);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } tag_t;

  logic [TAG_W-1:0]         ptr;
  logic [NUM_CHANNELS-1:0]  inflight;
  tag_t                     tag_pipe [DEPTH];
  tag_t                     tail;
  logic [NUM_CHANNELS-1:0]  eligible;
  logic                     gnt_vld;
  logic [TAG_W-1:0]         gnt_idx;
  logic [NUM_CHANNELS-1:0]  gnt_hot;
  logic [ADDRESS_WIDTH-1:0] gnt_addr;
  logic [NUM_CHANNELS-1:0]  cpl_hot;

  // A channel competes only when it has no read outstanding and is not
  // currently being handed data; this also keeps grant and completion of
  // the same channel from ever landing on one edge.
  assign eligible = data_req & ~inflight & ~data_rdy;

  // The oldest tag lines up with the cycle in which mem_rdata is valid.
  assign tail = tag_pipe[DEPTH-1];

  // Round-robin search starting after ptr, wrapping by explicit compare so
  // non-power-of-two channel counts never produce an out-of-range index.
  always_comb begin
    logic [TAG_W-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      cand = (cand == LAST_CH) ? '0 : cand + 1'b1;
      if (!gnt_vld && eligible[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Decode grant and completion into per-channel one-hots and select the granted address.
  always_comb begin
    gnt_hot  = '0;
    cpl_hot  = '0;
    gnt_addr = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (gnt_vld && (gnt_idx == TAG_W'(i))) begin
        gnt_hot[i] = 1'b1;
        gnt_addr   = data_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      end
      if (tail.vld && (tail.tag == TAG_W'(i))) begin
        cpl_hot[i] = 1'b1;
      end
    end
  end

  // Issue stage: register the BRAM address/enable and advance the priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      ptr       <= LAST_CH;
    end else begin
      mem_ren <= gnt_vld;
      if (gnt_vld) begin
        mem_raddr <= gnt_addr;
        ptr       <= gnt_idx;
      end
    end
  end

  // Tag shift register: carries the owner of each issued read down to the data-return cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{vld: gnt_vld, tag: gnt_idx};
      for (int s = 1; s < DEPTH; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  // Outstanding-read flags: set on grant, cleared on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      inflight <= (inflight & ~cpl_hot) | gnt_hot;
    end
  end

  // Completion: capture mem_rdata into the owner's data register and pulse its data_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rdy <= '0;
      data_out <= '0;
    end else begin
      data_rdy <= cpl_hot;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (cpl_hot[i]) begin
          data_out[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_read_arbiter.sv
module tb_rr_read_arbiter;

  localparam int AW = 13;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: 8 channels, READ_LATENCY=1
  logic           a_rst = 1'b1;
  logic [7:0]     a_req = '0;
  logic [8*AW-1:0] a_addr = '0;
  logic [7:0]     a_rdy;
  logic [8*DW-1:0] a_dout;
  logic [AW-1:0]  a_raddr;
  logic           a_ren;
  logic [DW-1:0]  a_rdata = '0;

  // Instance B: 8 channels, READ_LATENCY=3
  logic           b_rst = 1'b1;
  logic [7:0]     b_req = '0;
  logic [8*AW-1:0] b_addr = '0;
  logic [7:0]     b_rdy;
  logic [8*DW-1:0] b_dout;
  logic [AW-1:0]  b_raddr;
  logic           b_ren;
  logic [DW-1:0]  b_rdata = '0;
  logic [DW-1:0]  b_s1 = '0;
  logic [DW-1:0]  b_s2 = '0;

  // Instance C: 3 channels, READ_LATENCY=1
  logic           c_rst = 1'b1;
  logic [2:0]     c_req = '0;
  logic [3*AW-1:0] c_addr = '0;
  logic [2:0]     c_rdy;
  logic [3*DW-1:0] c_dout;
  logic [AW-1:0]  c_raddr;
  logic           c_ren;
  logic [DW-1:0]  c_rdata = '0;

  rr_read_arbiter #(.NUM_CHANNELS(8), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_a (
    .clk(clk), .rst(a_rst), .data_req(a_req), .data_addr(a_addr), .data_rdy(a_rdy),
    .data_out(a_dout), .mem_raddr(a_raddr), .mem_ren(a_ren), .mem_rdata(a_rdata));

  rr_read_arbiter #(.NUM_CHANNELS(8), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) u_b (
    .clk(clk), .rst(b_rst), .data_req(b_req), .data_addr(b_addr), .data_rdy(b_rdy),
    .data_out(b_dout), .mem_raddr(b_raddr), .mem_ren(b_ren), .mem_rdata(b_rdata));

  rr_read_arbiter #(.NUM_CHANNELS(3), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_c (
    .clk(clk), .rst(c_rst), .data_req(c_req), .data_addr(c_addr), .data_rdy(c_rdy),
    .data_out(c_dout), .mem_raddr(c_raddr), .mem_ren(c_ren), .mem_rdata(c_rdata));

  // BRAM contents as a pure function of address.
  function automatic logic [7:0] mem_f(input logic [12:0] a);
    if (a == 13'h010) return 8'hA5;
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h3C;
  endfunction

  // BRAM read models
  always @(posedge clk) begin
    if (a_ren) a_rdata <= mem_f(a_raddr);
    if (c_ren) c_rdata <= mem_f(c_raddr);
    if (b_ren) b_s1 <= mem_f(b_raddr);
    b_s2    <= b_s1;
    b_rdata <= b_s2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Each reset task ends at the falling edge of the first post-reset cycle.
  task automatic reset_a();
    @(negedge clk); a_rst = 1'b1; a_req = '0;
    @(negedge clk); a_rst = 1'b0;
  endtask
  task automatic reset_b();
    @(negedge clk); b_rst = 1'b1; b_req = '0;
    @(negedge clk); b_rst = 1'b0;
  endtask
  task automatic reset_c();
    @(negedge clk); c_rst = 1'b1; c_req = '0;
    @(negedge clk); c_rst = 1'b0;
  endtask

  typedef struct {
    int         phase;
    logic       rst_before;
    logic [7:0] req;
    logic       exp_ren;
    logic [12:0] exp_raddr;
    logic [7:0] exp_rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input int p, input logic rb, input logic [7:0] req,
                                  input logic ren, input logic [12:0] ra, input logic [7:0] rdy);
    vec_t v;
    v.phase = p; v.rst_before = rb; v.req = req;
    v.exp_ren = ren; v.exp_raddr = ra; v.exp_rdy = rdy;
    vecs.push_back(v);
  endfunction

  // One vector per cycle on instance A: check registered outputs, then drive data_req.
  task automatic run_phase(input int p);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == p) begin
        if (vecs[i].rst_before) reset_a();
        else @(negedge clk);
        chk($sformatf("p%0d_v%0d_ren", p, i), 32'(a_ren), 32'(vecs[i].exp_ren));
        chk($sformatf("p%0d_v%0d_raddr", p, i), 32'(a_raddr), 32'(vecs[i].exp_raddr));
        chk($sformatf("p%0d_v%0d_rdy", p, i), 32'(a_rdy), 32'(vecs[i].exp_rdy));
        a_req = vecs[i].req;
      end
    end
  endtask

  logic        exp_ren;
  logic [12:0] exp_ra;
  logic [7:0]  exp_rdy;
  logic [2:0]  exp_rdy3;
  int          g;

  initial begin
    // Phase 1: single channel 0, addr 0x010 -> 0xA5, grant in v0, data_rdy in v3
    add_vec(1, 1'b1, 8'h01, 1'b0, 13'h000, 8'h00);
    add_vec(1, 1'b0, 8'h01, 1'b1, 13'h010, 8'h00);
    add_vec(1, 1'b0, 8'h01, 1'b0, 13'h010, 8'h00);
    add_vec(1, 1'b0, 8'h00, 1'b0, 13'h010, 8'h01);
    add_vec(1, 1'b0, 8'h00, 1'b0, 13'h010, 8'h00);
    // Phase 2: all 8 at once with addr i*900; each channel drops req the cycle after
    // its grant (channel 4 included), so no channel is granted twice.
    add_vec(2, 1'b1, 8'hFF, 1'b0, 13'd0,    8'h00);
    add_vec(2, 1'b0, 8'hFE, 1'b1, 13'd0,    8'h00);
    add_vec(2, 1'b0, 8'hFC, 1'b1, 13'd900,  8'h00);
    add_vec(2, 1'b0, 8'hF8, 1'b1, 13'd1800, 8'h01);
    add_vec(2, 1'b0, 8'hF0, 1'b1, 13'd2700, 8'h02);
    add_vec(2, 1'b0, 8'hE0, 1'b1, 13'd3600, 8'h04);
    add_vec(2, 1'b0, 8'hC0, 1'b1, 13'd4500, 8'h08);
    add_vec(2, 1'b0, 8'h80, 1'b1, 13'd5400, 8'h10);
    add_vec(2, 1'b0, 8'h00, 1'b1, 13'd6300, 8'h20);
    add_vec(2, 1'b0, 8'h00, 1'b0, 13'd6300, 8'h40);
    add_vec(2, 1'b0, 8'h00, 1'b0, 13'd6300, 8'h80);
    add_vec(2, 1'b0, 8'h00, 1'b0, 13'd6300, 8'h00);

    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // ---- Single channel
    a_addr = '0;
    a_addr[0*AW +: AW] = 13'h010;
    run_phase(1);
    chk("single_dout_after_rdy", 32'(a_dout[7:0]), 32'h0000_00A5);
    repeat (3) @(negedge clk);
    chk("single_dout_held", 32'(a_dout[7:0]), 32'h0000_00A5);
    chk("single_others_zero", 32'(a_dout[63:8] != '0), 32'd0);

    // ---- All channels at once
    for (int i = 0; i < 8; i++) a_addr[i*AW +: AW] = 13'(i * 900);
    run_phase(2);
    for (int i = 0; i < 8; i++)
      chk($sformatf("all_dout_ch%0d", i), 32'(a_dout[i*DW +: DW]), 32'(mem_f(13'(i * 900))));

    // ---- Back-to-back on channel 3 with channel 5 interleaving
    reset_a();
    a_addr = '0;
    a_addr[5*AW +: AW] = 13'h155;
    exp_ra = '0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      g = k - 1;
      if (k >= 1 && g % 4 == 0) begin exp_ren = 1'b1; exp_ra = 13'h100 + 13'(g / 4); end
      else if (k >= 1 && g % 4 == 1) begin exp_ren = 1'b1; exp_ra = 13'h155; end
      else exp_ren = 1'b0;
      exp_rdy = ((k >= 3 && k % 4 == 3) ? 8'h08 : 8'h00) | ((k >= 4 && k % 4 == 0) ? 8'h20 : 8'h00);
      chk($sformatf("b2b_c%0d_ren", k), 32'(a_ren), 32'(exp_ren));
      chk($sformatf("b2b_c%0d_raddr", k), 32'(a_raddr), 32'(exp_ra));
      chk($sformatf("b2b_c%0d_rdy", k), 32'(a_rdy), 32'(exp_rdy));
      if (exp_rdy[3]) chk($sformatf("b2b_c%0d_dout3", k), 32'(a_dout[3*DW +: DW]), 32'(mem_f(13'h100 + 13'((k - 3) / 4))));
      if (exp_rdy[5]) chk($sformatf("b2b_c%0d_dout5", k), 32'(a_dout[5*DW +: DW]), 32'(mem_f(13'h155)));
      if (k % 4 == 0) a_addr[3*AW +: AW] = 13'h100 + 13'(k / 4);
      a_req = 8'h28;
    end
    a_req = '0;

    // ---- Reset mid-flight, READ_LATENCY=3
    reset_b();
    b_addr = '0;
    b_addr[0*AW +: AW] = 13'h020;
    b_addr[1*AW +: AW] = 13'h021;
    b_addr[2*AW +: AW] = 13'h030;
    b_req = 8'h04;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("rl3_issue_ren", 32'(b_ren), 32'd1);
        chk("rl3_issue_raddr", 32'(b_raddr), 32'h030);
        b_req = '0;
      end
      chk($sformatf("rl3_c%0d_rdy", k), 32'(b_rdy), (k == 5) ? 32'h04 : 32'h00);
    end
    chk("rl3_dout2", 32'(b_dout[2*DW +: DW]), 32'(mem_f(13'h030)));
    b_req = 8'h03;
    @(negedge clk);
    chk("mid_g0_ren", 32'(b_ren), 32'd1);
    chk("mid_g0_raddr", 32'(b_raddr), 32'h020);
    @(negedge clk);
    chk("mid_g1_raddr", 32'(b_raddr), 32'h021);
    b_rst = 1'b1; b_req = '0;
    @(negedge clk);
    b_rst = 1'b0;
    chk("mid_rst_rdy", 32'(b_rdy), 32'd0);
    chk("mid_rst_dout_zero", 32'(b_dout != '0), 32'd0);
    chk("mid_rst_ren", 32'(b_ren), 32'd0);
    chk("mid_rst_raddr", 32'(b_raddr), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("mid_quiet%0d_rdy", k), 32'(b_rdy), 32'd0);
      chk($sformatf("mid_quiet%0d_ren", k), 32'(b_ren), 32'd0);
    end
    b_req = 8'h03;
    @(negedge clk);
    chk("mid_first_ren", 32'(b_ren), 32'd1);
    chk("mid_first_is_ch0", 32'(b_raddr), 32'h020);
    @(negedge clk);
    chk("mid_second_is_ch1", 32'(b_raddr), 32'h021);
    b_req = '0;

    // ---- Non-power-of-two wrap, 3 channels, channels 0 and 2 requesting
    reset_c();
    c_addr = '0;
    c_addr[0*AW +: AW] = 13'h040;
    c_addr[1*AW +: AW] = 13'h041;
    c_addr[2*AW +: AW] = 13'h042;
    exp_ra = '0;
    for (int k = 0; k < 13; k++) begin
      if (k > 0) @(negedge clk);
      g = k - 1;
      if (k >= 1 && g % 4 == 0) begin exp_ren = 1'b1; exp_ra = 13'h040; end
      else if (k >= 1 && g % 4 == 1) begin exp_ren = 1'b1; exp_ra = 13'h042; end
      else exp_ren = 1'b0;
      exp_rdy3 = ((k >= 3 && k % 4 == 3) ? 3'b001 : 3'b000) | ((k >= 4 && k % 4 == 0) ? 3'b100 : 3'b000);
      chk($sformatf("wrap_c%0d_ren", k), 32'(c_ren), 32'(exp_ren));
      chk($sformatf("wrap_c%0d_raddr", k), 32'(c_raddr), 32'(exp_ra));
      chk($sformatf("wrap_c%0d_rdy", k), 32'(c_rdy), 32'(exp_rdy3));
      if (exp_rdy3[0]) chk($sformatf("wrap_c%0d_dout0", k), 32'(c_dout[0*DW +: DW]), 32'(mem_f(13'h040)));
      if (exp_rdy3[2]) chk($sformatf("wrap_c%0d_dout2", k), 32'(c_dout[2*DW +: DW]), 32'(mem_f(13'h042)));
      c_req = 3'b101;
    end
    c_req = '0;
    @(negedge clk);
    chk("wrap_dout1_untouched", 32'(c_dout[1*DW +: DW]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
